// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the ADC burst streaming path: FSM states,
// packet header bytes and word-size helper.
package adc_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SEND,
        ST_TRAILER,
        ST_DONE
    } state_t;

    localparam logic [7:0] HDR_BYTE0 = 8'hAD;
    localparam logic [7:0] HDR_BYTE1 = 8'h92;
    localparam int         HDR_BYTES = 4;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Loads a word plus a byte count and emits the bytes MSB-first on a
// valid/ready stream with registered outputs; flags the final byte's transfer.
module word_serializer
#(
    parameter int WORD_WIDTH = 48,
    parameter int CNT_W      = $clog2(WORD_WIDTH / 8) + 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [CNT_W-1:0]      nbytes,
    input  logic                  mark_sof,
    input  logic                  mark_eof,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  tx_sof,
    output logic                  tx_eof,
    output logic                  last_xfer
);

    logic [WORD_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      rem;
    logic                  eof_pend;
    logic                  xfer;

    assign xfer      = tx_valid & tx_ready;
    assign last_xfer = xfer & (rem == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
            tx_data  <= 8'h00;
            rem      <= '0;
            eof_pend <= 1'b0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= word[WORD_WIDTH-1 -: 8];
            tx_sof   <= mark_sof;
            tx_eof   <= mark_eof && (nbytes == CNT_W'(1));
            rem      <= nbytes - CNT_W'(1);
            eof_pend <= mark_eof;
        end else if (xfer) begin
            if (rem != '0) begin
                tx_data <= shreg[WORD_WIDTH-1 -: 8];
                tx_sof  <= 1'b0;
                tx_eof  <= eof_pend && (rem == CNT_W'(1));
                rem     <= rem - CNT_W'(1);
            end else begin
                tx_valid <= 1'b0;
                tx_sof   <= 1'b0;
                tx_eof   <= 1'b0;
            end
        end
    end

    // Remaining bytes wait MSB-aligned; the presented byte already left.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= word << 8;
        end else if (xfer) begin
            shreg <= shreg << 8;
        end
    end

endmodule

// File: rtl/adc_burst_scheduler.sv
// ADC sample FIFO sequencer: gates sample writes, tracks occupancy and drains
// framed bursts as a byte stream. Optional XOR trailer byte: ADC_BURST_TRAILER_EN.
module adc_burst_scheduler
    import adc_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 48,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_ENTRIES   = 255,
    parameter int BURST_LEN     = 16
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     adc_word_valid,
    input  logic [DATA_WIDTH-1:0]    adc_word,
    output logic [DATA_WIDTH-1:0]    fifo_data_in,
    output logic                     fifo_write_enabled,
    output logic                     fifo_read_enabled,
    input  logic [DATA_WIDTH-1:0]    fifo_data_out,
    input  logic                     fifo_data_out_valid,
    input  logic                     fifo_empty,
    input  logic                     fifo_full,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     tx_sof,
    output logic                     tx_eof,
    output logic [15:0]              overflow_count,
    output logic [ADDRESS_WIDTH:0]   occupancy
);

    localparam int W     = bytes_per_word(DATA_WIDTH);
    localparam int SER_W = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
    localparam int CNT_W = $clog2(SER_W / 8) + 1;
    localparam int OCC_W = ADDRESS_WIDTH + 1;
`ifdef ADC_BURST_TRAILER_EN
    localparam bit TRAILER_EN = 1'b1;
`else
    localparam bit TRAILER_EN = 1'b0;
`endif

    state_t             state, state_nxt;
    logic [15:0]        seq;
    logic [OCC_W-1:0]   words_left;
    logic [7:0]         payload_xor;
    logic               drop, start, capture, rd_req, last_xfer;
    logic               ser_load, ser_sof, ser_eof;
    logic [SER_W-1:0]   ser_word, hdr_word, pay_word, trl_word;
    logic [CNT_W-1:0]   ser_nbytes;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fifo_data_in       = adc_word;
    assign fifo_write_enabled = enable & adc_word_valid & ~fifo_full;
    assign drop               = enable & adc_word_valid & fifo_full;

    assign hdr_word = SER_W'({HDR_BYTE0, HDR_BYTE1, seq}) << (SER_W - 32);
    assign pay_word = SER_W'(fifo_data_out) << (SER_W - DATA_WIDTH);
    assign trl_word = SER_W'(payload_xor) << (SER_W - 8);

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        capture    = 1'b0;
        rd_req     = 1'b0;
        ser_load   = 1'b0;
        ser_word   = '0;
        ser_nbytes = '0;
        ser_sof    = 1'b0;
        ser_eof    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && occupancy >= OCC_W'(BURST_LEN)) begin
                    start      = 1'b1;
                    ser_load   = 1'b1;
                    ser_word   = hdr_word;
                    ser_nbytes = CNT_W'(HDR_BYTES);
                    ser_sof    = 1'b1;
                    state_nxt  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (last_xfer) state_nxt = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (!fifo_empty) begin
                    rd_req    = 1'b1;
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (fifo_data_out_valid) begin
                    capture    = 1'b1;
                    ser_load   = 1'b1;
                    ser_word   = pay_word;
                    ser_nbytes = CNT_W'(W);
                    ser_eof    = !TRAILER_EN && (words_left == OCC_W'(1));
                    state_nxt  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_xfer) begin
                    if (words_left != '0) begin
                        state_nxt = ST_RD_REQ;
                    end else if (TRAILER_EN) begin
                        // Trailer loads on the same edge the last payload byte leaves.
                        ser_load   = 1'b1;
                        ser_word   = trl_word;
                        ser_nbytes = CNT_W'(1);
                        ser_eof    = 1'b1;
                        state_nxt  = ST_TRAILER;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_TRAILER: begin
                if (last_xfer) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            seq               <= 16'h0000;
            words_left        <= '0;
            occupancy         <= '0;
            overflow_count    <= 16'h0000;
            fifo_read_enabled <= 1'b0;
        end else begin
            state             <= state_nxt;
            fifo_read_enabled <= rd_req;
            if (start) begin
                words_left <= OCC_W'(BURST_LEN);
            end else if (capture) begin
                words_left <= words_left - OCC_W'(1);
            end
            if (state == ST_DONE) seq <= seq + 16'd1;
            case ({fifo_write_enabled, fifo_read_enabled})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (drop) overflow_count <= sat_inc(overflow_count);
        end
    end

`ifdef ADC_BURST_TRAILER_EN
    function automatic logic [7:0] xor_fold(input logic [DATA_WIDTH-1:0] w);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < W; i++) acc = acc ^ w[8*i +: 8];
        return acc;
    endfunction

    always_ff @(posedge clk) begin
        if (start) begin
            payload_xor <= 8'h00;
        end else if (capture) begin
            payload_xor <= payload_xor ^ xor_fold(fifo_data_out);
        end
    end
`else
    assign payload_xor = 8'h00;
`endif

    word_serializer #(
        .WORD_WIDTH (SER_W),
        .CNT_W      (CNT_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (ser_word),
        .nbytes    (ser_nbytes),
        .mark_sof  (ser_sof),
        .mark_eof  (ser_eof),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_sof    (tx_sof),
        .tx_eof    (tx_eof),
        .last_xfer (last_xfer)
    );

endmodule
